// File: rtl/ysyx_22050598_mem_arbiter.sv
// Two-requester (icache/dcache) arbiter that splits each 128-bit line into two 64-bit memory beats.
// Define YSYX_22050598_ARB_RR_EN for round-robin arbitration; the default is fixed dcache priority.
module ysyx_22050598_mem_arbiter #(
    parameter int unsigned AW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [127:0]  i_rdata,
    output logic          i_done,
    input  logic          d_req_r,
    input  logic          d_req_w,
    input  logic [AW-1:0] d_addr,
    input  logic [127:0]  d_wdata,
    output logic [127:0]  d_rdata,
    output logic          d_done,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_ready,
    input  logic [63:0]   mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StDone} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [127:0]  wdata_q, wdata_d;
    logic [127:0]  line_q, line_d;
    logic          d_req;
    logic          grant;
    logic          beat_hi;

    assign d_req = d_req_r | d_req_w;

`ifdef YSYX_22050598_ARB_RR_EN
    logic last_q, last_d;

    // On contention favour whoever was not served last.
    always_comb begin
        grant = d_req;
        if (i_req && d_req) begin
            grant = ~last_q;
        end
    end
`else
    assign grant = d_req;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        line_d  = line_q;
`ifdef YSYX_22050598_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    state_d = StBeat0;
                    owner_d = grant;
                    addr_d  = grant ? d_addr : i_addr;
                    we_d    = grant & d_req_w;
                    wdata_d = grant ? d_wdata : '0;
`ifdef YSYX_22050598_ARB_RR_EN
                    last_d  = grant;
`endif
                end
            end
            StBeat0: begin
                if (mem_ready) begin
                    line_d[63:0] = mem_rdata;
                    state_d      = StBeat1;
                end
            end
            StBeat1: begin
                if (mem_ready) begin
                    line_d[127:64] = mem_rdata;
                    state_d        = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
`ifdef YSYX_22050598_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
`ifdef YSYX_22050598_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign beat_hi = (state_q == StBeat1);

    // Beat outputs are gated by state so they read as zero outside the beat phases.
    always_comb begin
        mem_valid = (state_q == StBeat0) || (state_q == StBeat1);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (mem_valid) begin
            mem_we    = we_q;
            mem_addr  = {addr_q[AW-1:4], (beat_hi ? 4'h8 : 4'h0)};
            mem_wdata = beat_hi ? wdata_q[127:64] : wdata_q[63:0];
            mem_wmask = {8{we_q}};
        end
    end

    assign i_done  = (state_q == StDone) && !owner_q;
    assign d_done  = (state_q == StDone) && owner_q;
    assign i_rdata = line_q;
    assign d_rdata = line_q;

endmodule

// File: doc/ysyx_22050598_mem_arbiter.md
YSYX_22050598_MEM_ARBITER -- requirements
Module: ysyx_22050598_mem_arbiter

Interface
REQ-001 SHALL have parameter: AW, 64, requester and memory address width.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: i_req  in  1  icache line-fill request, held until i_done.
REQ-005 SHALL have ports: i_addr  in  AW  icache line address.
REQ-006 SHALL have ports: i_rdata  out  128  icache line data, valid with i_done.
REQ-007 SHALL have ports: i_done  out  1  icache transaction complete, 1-cycle pulse.
REQ-008 SHALL have ports: d_req_r / d_req_w  in  1 each  dcache read-fill / write-back request, held until d_done.
REQ-009 SHALL have ports: d_addr  in  AW; d_wdata  in  128; d_rdata  out  128; d_done  out  1 -- dcache equivalents.
REQ-010 SHALL have ports: mem_valid  out  1; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  64; mem_wmask  out  8 -- one 64-bit beat request.
REQ-011 SHALL have ports: mem_ready  in  1  beat accepted/completed this cycle; mem_rdata  in  64  read beat data, valid with mem_ready.

Function
REQ-012 SHALL implement FSM states IDLE, BEAT0, BEAT1, DONE; reset state IDLE.
REQ-013 SHALL sample requests only in IDLE; grant latched into owner register (0=icache, 1=dcache); IDLE->BEAT0 on any request next cycle.
REQ-014 SHALL, with d_req_r and d_req_w both high, treat it as write (d_req_w wins).
REQ-015 SHALL latch granted address, write flag and wdata at grant; later changes of requester inputs ignored until DONE.
REQ-016 SHALL drive mem_valid=1 in BEAT0 and BEAT1 only; mem_addr={addr[AW-1:4],4'h0} in BEAT0, {addr[AW-1:4],4'h8} in BEAT1.
REQ-017 SHALL drive mem_wmask=8'hFF on write beats, 8'h00 on reads; mem_wdata = wdata[63:0] in BEAT0, wdata[127:64] in BEAT1.
REQ-018 SHALL stay in a BEAT state while mem_ready=0 (unbounded wait); advance BEAT0->BEAT1->DONE on mem_ready=1.
REQ-019 SHALL capture mem_rdata into line buffer bits [63:0] at BEAT0 ready, [127:64] at BEAT1 ready.
REQ-020 SHALL in DONE pulse exactly one of i_done/d_done for owner for one cycle, then return to IDLE; no back-to-back grant in the DONE cycle.
REQ-021 SHALL present i_rdata/d_rdata from the line buffer; value only guaranteed during the done pulse (write-back: don't-care).
REQ-022 SHALL minimum transaction latency grant-to-done = 3 cycles after IDLE (mem_ready always 1): BEAT0, BEAT1, DONE.
REQ-023 SHALL ignore a requester dropping its request mid-transaction; transaction completes and done still pulses.
REQ-024 SHALL never assert mem_valid in IDLE or DONE; mem_ready outside BEAT states ignored.

Reset
REQ-025 SHALL on rst=0 asynchronously force state IDLE, owner 0, mem_valid/mem_we/i_done/d_done 0, mem_addr/mem_wdata/mem_wmask/line buffer/latched request 0.
REQ-026 SHALL abort any in-flight transaction on reset with no done pulse; after rst release first grant is evaluated in the first IDLE cycle.

Configuration
REQ-027 SHALL with YSYX_22050598_ARB_RR_EN defined use round-robin: on contention grant the requester not granted last (last-grant register reset to icache, so dcache wins first contention).
REQ-028 SHALL without YSYX_22050598_ARB_RR_EN use fixed priority: dcache always wins contention; no last-grant register.

Verification
REQ-029 SHALL cover: i_req=1, i_addr=0x80000014, mem_ready=1, mem_rdata=beat index pattern -> mem_addr 0x80000010 then 0x80000018, i_rdata={beat1,beat0}, i_done 1 cycle, 3 cycles after grant.
REQ-030 SHALL cover: d_req_w=1, d_addr=0x80001000, d_wdata=128'hA..A_B..B -> mem_we=1, wmask 0xFF, wdata 0xB..B at 0x80001000 then 0xA..A at 0x80001008, d_done pulse.
REQ-031 SHALL cover: i_req and d_req_r simultaneously, held, twice -> fixed: dcache, dcache; with YSYX_22050598_ARB_RR_EN: dcache then icache.
REQ-032 SHALL cover: mem_ready low 5 cycles in BEAT0 and 3 in BEAT1 -> mem_addr/mem_wdata stable, no done until both beats ready, data correct.
REQ-033 SHALL cover: rst asserted during BEAT1 -> all outputs 0 immediately, no done pulse; new i_req after release completes normally.
